// File: rtl/button_event_decoder.sv
// +--------------------------------------------------------------------------+
// | Module      : button_event_decoder                                       |
// | Description : Turns a debounced button level into one-cycle strobes:    |
// |               press, release, short click, long press and auto-repeat.   |
// |               Auto-repeat is built only when BUTTON_AUTO_REPEAT_EN is    |
// |               defined; otherwise repeat_pulse is tied low.               |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
`default_nettype none

module button_event_decoder #(
  parameter int LONG_MAX   = 100_000_000,
  parameter int REPEAT_MAX = 25_000_000
) (
  input  logic clk,
  input  logic rst_a_p,
  input  logic btn_in,
  output logic held,
  output logic press_pulse,
  output logic release_pulse,
  output logic short_pulse,
  output logic long_pulse,
  output logic repeat_pulse
);

  localparam int                HOLD_W  = $clog2(LONG_MAX + 1);
  localparam logic [HOLD_W-1:0] HOLD_TC = HOLD_W'(LONG_MAX - 1);

  if ((LONG_MAX < 2) || (REPEAT_MAX < 1)) begin : g_param_check
    $error("button_event_decoder: LONG_MAX must be >= 2 and REPEAT_MAX >= 1");
  end

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_LONG    = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic                btn_q;
  logic                press_q, press_d;
  logic                release_q, release_d;
  logic                short_q, short_d;
  logic                long_q, long_d;
  logic                rise, fall;

`ifdef BUTTON_AUTO_REPEAT_EN
  localparam int               RPT_W  = $clog2(REPEAT_MAX + 1);
  localparam logic [RPT_W-1:0] RPT_TC = RPT_W'(REPEAT_MAX - 1);

  logic [RPT_W-1:0]    rpt_cnt_q, rpt_cnt_d;
  logic                repeat_q, repeat_d;
`endif

  assign rise = btn_in & ~btn_q;
  assign fall = ~btn_in & btn_q;

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    press_d    = 1'b0;
    release_d  = 1'b0;
    short_d    = 1'b0;
    long_d     = 1'b0;
`ifdef BUTTON_AUTO_REPEAT_EN
    rpt_cnt_d  = rpt_cnt_q;
    repeat_d   = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        if (rise) begin
          state_d    = ST_PRESSED;
          press_d    = 1'b1;
          hold_cnt_d = '0;
        end
      end

      // A release on the terminal-count cycle still counts as a short click.
      ST_PRESSED: begin
        if (fall) begin
          state_d    = ST_IDLE;
          release_d  = 1'b1;
          short_d    = 1'b1;
          hold_cnt_d = '0;
        end else if (hold_cnt_q == HOLD_TC) begin
          state_d    = ST_LONG;
          long_d     = 1'b1;
          hold_cnt_d = '0;
`ifdef BUTTON_AUTO_REPEAT_EN
          rpt_cnt_d  = '0;
`endif
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end

      ST_LONG: begin
        if (fall) begin
          state_d    = ST_IDLE;
          release_d  = 1'b1;
          hold_cnt_d = '0;
`ifdef BUTTON_AUTO_REPEAT_EN
          rpt_cnt_d  = '0;
`endif
        end
`ifdef BUTTON_AUTO_REPEAT_EN
        else if (rpt_cnt_q == RPT_TC) begin
          repeat_d  = 1'b1;
          rpt_cnt_d = '0;
        end else begin
          rpt_cnt_d = rpt_cnt_q + RPT_W'(1);
        end
`endif
      end

      default: begin
        state_d    = ST_IDLE;
        hold_cnt_d = '0;
`ifdef BUTTON_AUTO_REPEAT_EN
        rpt_cnt_d  = '0;
`endif
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_a_p) begin
      state_q    <= ST_IDLE;
      hold_cnt_q <= '0;
      btn_q      <= 1'b0;
      press_q    <= 1'b0;
      release_q  <= 1'b0;
      short_q    <= 1'b0;
      long_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      btn_q      <= btn_in;
      press_q    <= press_d;
      release_q  <= release_d;
      short_q    <= short_d;
      long_q     <= long_d;
    end
  end

`ifdef BUTTON_AUTO_REPEAT_EN
  always_ff @(posedge clk) begin
    if (rst_a_p) begin
      rpt_cnt_q <= '0;
      repeat_q  <= 1'b0;
    end else begin
      rpt_cnt_q <= rpt_cnt_d;
      repeat_q  <= repeat_d;
    end
  end

  assign repeat_pulse = repeat_q;
`else
  assign repeat_pulse = 1'b0;
`endif

  assign held          = btn_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign short_pulse   = short_q;
  assign long_pulse    = long_q;

endmodule

`default_nettype wire
